// File: rtl/comm_rx_packet_ctrl_pkg.sv
// Shared types and constants for the comm_rx packet controller.
// Packets carry payload, then CRC, then a stop byte; only the payload is forwarded.
package comm_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2,
        DRAIN = 2'd3
    } rx_state_e;

    localparam int CRC_BYTES      = 4;
    localparam int STOP_BYTES     = 1;
    localparam int OVERHEAD_BYTES = CRC_BYTES + STOP_BYTES;

    // First received bit of each byte lands in bit 7.
    localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/comm_rx_packet_ctrl_if.sv
// Payload byte stream from the packet controller to its consumer.
interface comm_rx_packet_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_last;
    logic [ADDR_W-1:0] pkt_len;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        output pkt_len,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        input  pkt_len,
        output out_ready
    );
endinterface

// File: rtl/comm_rx_byte_buffer.sv
// Single packet buffer: synchronous write, combinational read, contents not reset.
module comm_rx_byte_buffer #(
    parameter int MAX_BYTES = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              inclk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);
    logic [7:0] mem [MAX_BYTES];

    always_ff @(posedge inclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/comm_rx_packet_ctrl.sv
// Assembles comm_receiver bits into a packet buffer, validates the packet and
// drains its payload (CRC and stop byte stripped) over a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for decoding to rise with rx_enable set
// RECV  | shifting bits into bytes, writing bytes to the buffer
// CHECK | one cycle: decide deliver / count error / ignore false trigger
// DRAIN | presenting payload bytes downstream; new packets are dropped
module comm_rx_packet_ctrl
    import comm_rx_pkg::*;
#(
    parameter int MAX_BYTES = 256,
    parameter int ADDR_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                  inclk,
    input  logic                  reset,
    input  logic                  rx_enable,
    input  logic                  decoding,
    input  logic                  start_byte_detected,
    input  logic                  decoding_failed,
    input  logic                  new_bit_clk,
    input  logic                  new_bit,
    comm_rx_packet_ctrl_if.master out_if,
    output logic                  busy,
    output logic [CNT_W-1:0]      ok_count,
    output logic [CNT_W-1:0]      err_count,
    output logic [CNT_W-1:0]      drop_count,
    output logic                  overflow
);
    localparam logic [ADDR_W:0]   MAX_CNT   = (ADDR_W+1)'(MAX_BYTES);
    localparam logic [ADDR_W:0]   OVH_CNT   = (ADDR_W+1)'(OVERHEAD_BYTES);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  STAT_MAX  = '1;
    localparam logic [CNT_W-1:0]  STAT_ONE  = CNT_W'(1);

    rx_state_e         state_q, state_n;
    logic              dec_q, nbc_q;
    logic [2:0]        bit_cnt_q, bit_cnt_n;
    logic [7:0]        shift_q, shift_n, shifted;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_n;
    logic [ADDR_W:0]   byte_cnt_q, byte_cnt_n;
    logic [ADDR_W:0]   payload;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_n;
    logic [ADDR_W-1:0] pkt_len_q, pkt_len_n;
    logic              start_seen_q, start_seen_n;
    logic              failed_q, failed_n;
    logic              partial_q, partial_n;
    logic              ovf_q, ovf_n;
    logic              overflow_q, overflow_n;
    logic [CNT_W-1:0]  ok_q, ok_n, err_q, err_n, drop_q, drop_n;
    logic              rise_dec, fall_dec, rise_nbc;
    logic              good;
    logic              drain_last;
    logic              buf_we;
    logic [7:0]        buf_rdata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == STAT_MAX) ? v : v + STAT_ONE;
    endfunction

    assign rise_dec = decoding & ~dec_q;
    assign fall_dec = ~decoding & dec_q;
    assign rise_nbc = new_bit_clk & ~nbc_q;

    assign shifted    = MSB_FIRST ? {shift_q[6:0], new_bit} : {new_bit, shift_q[7:1]};
    assign payload    = byte_cnt_q - OVH_CNT;
    assign good       = start_seen_q & ~failed_q & ~partial_q & ~ovf_q &
                        (byte_cnt_q >= OVH_CNT) & (payload >= CNT_ONE);
    assign drain_last = (rd_ptr_q == pkt_len_q - ADDR_ONE);

    comm_rx_byte_buffer #(
        .MAX_BYTES (MAX_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_buf (
        .inclk (inclk),
        .we    (buf_we),
        .waddr (wr_ptr_q),
        .wdata (shifted),
        .raddr (rd_ptr_q),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_n      = state_q;
        bit_cnt_n    = bit_cnt_q;
        shift_n      = shift_q;
        wr_ptr_n     = wr_ptr_q;
        byte_cnt_n   = byte_cnt_q;
        rd_ptr_n     = rd_ptr_q;
        pkt_len_n    = pkt_len_q;
        start_seen_n = start_seen_q;
        failed_n     = failed_q;
        partial_n    = partial_q;
        ovf_n        = ovf_q;
        overflow_n   = overflow_q;
        ok_n         = ok_q;
        err_n        = err_q;
        drop_n       = drop_q;
        buf_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise_dec && rx_enable) begin
                    state_n    = RECV;
                    bit_cnt_n  = '0;
                    wr_ptr_n   = '0;
                    byte_cnt_n = '0;
                    ovf_n      = 1'b0;
                end
            end
            RECV: begin
                if (rise_nbc) begin
                    shift_n   = shifted;
                    bit_cnt_n = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q == MAX_CNT) begin
                            overflow_n = 1'b1;
                            ovf_n      = 1'b1;
                        end else begin
                            buf_we     = 1'b1;
                            wr_ptr_n   = wr_ptr_q + ADDR_ONE;
                            byte_cnt_n = byte_cnt_q + CNT_ONE;
                        end
                    end
                end
                // A bit arriving with the fall is already counted in bit_cnt_n.
                if (fall_dec) begin
                    start_seen_n = start_byte_detected;
                    failed_n     = decoding_failed;
                    partial_n    = (bit_cnt_n != 3'd0);
                    state_n      = CHECK;
                end
            end
            CHECK: begin
                if (good) begin
                    pkt_len_n = payload[ADDR_W-1:0];
                    rd_ptr_n  = '0;
                    ok_n      = sat_inc(ok_q);
                    state_n   = DRAIN;
                end else if (start_seen_q) begin
                    err_n   = sat_inc(err_q);
                    state_n = IDLE;
                end else begin
                    state_n = IDLE;
                end
            end
            DRAIN: begin
                if (out_if.out_ready) begin
                    rd_ptr_n = rd_ptr_q + ADDR_ONE;
                    if (drain_last) begin
                        state_n = IDLE;
                    end
                end
                if (fall_dec && start_byte_detected) begin
                    drop_n = sat_inc(drop_q);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            dec_q        <= 1'b0;
            nbc_q        <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            wr_ptr_q     <= '0;
            byte_cnt_q   <= '0;
            rd_ptr_q     <= '0;
            pkt_len_q    <= '0;
            start_seen_q <= 1'b0;
            failed_q     <= 1'b0;
            partial_q    <= 1'b0;
            ovf_q        <= 1'b0;
            overflow_q   <= 1'b0;
            ok_q         <= '0;
            err_q        <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_n;
            dec_q        <= decoding;
            nbc_q        <= new_bit_clk;
            bit_cnt_q    <= bit_cnt_n;
            shift_q      <= shift_n;
            wr_ptr_q     <= wr_ptr_n;
            byte_cnt_q   <= byte_cnt_n;
            rd_ptr_q     <= rd_ptr_n;
            pkt_len_q    <= pkt_len_n;
            start_seen_q <= start_seen_n;
            failed_q     <= failed_n;
            partial_q    <= partial_n;
            ovf_q        <= ovf_n;
            overflow_q   <= overflow_n;
            ok_q         <= ok_n;
            err_q        <= err_n;
            drop_q       <= drop_n;
        end
    end

    // Data is gated so the stream reads as zero outside DRAIN (buffer has no reset).
    assign out_if.out_valid = (state_q == DRAIN);
    assign out_if.out_data  = (state_q == DRAIN) ? buf_rdata : 8'h00;
    assign out_if.out_last  = (state_q == DRAIN) & drain_last;
    assign out_if.pkt_len   = pkt_len_q;

    assign busy       = (state_q != IDLE);
    assign ok_count   = ok_q;
    assign err_count  = err_q;
    assign drop_count = drop_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_comm_rx_packet_ctrl.sv
// Directed bench for comm_rx_packet_ctrl with an 8-byte buffer; payload beats
// are predicted into a queue and compared as the stream hands them over.
module tb_comm_rx_packet_ctrl;
    localparam int MAX_BYTES = 8;
    localparam int ADDR_W    = 3;
    localparam int CNT_W     = 16;

    typedef struct {
        logic [7:0]        d;
        logic              l;
        logic [ADDR_W-1:0] len;
    } beat_t;

    logic inclk = 1'b0;
    logic reset = 1'b1;
    logic rx_enable = 1'b1;
    logic decoding = 1'b0;
    logic start_byte_detected = 1'b0;
    logic decoding_failed = 1'b0;
    logic new_bit_clk = 1'b0;
    logic new_bit = 1'b0;
    logic busy;
    logic [CNT_W-1:0] ok_count, err_count, drop_count;
    logic overflow;

    comm_rx_packet_ctrl_if #(.ADDR_W(ADDR_W)) io ();

    comm_rx_packet_ctrl #(
        .MAX_BYTES (MAX_BYTES),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W)
    ) dut (
        .inclk               (inclk),
        .reset               (reset),
        .rx_enable           (rx_enable),
        .decoding            (decoding),
        .start_byte_detected (start_byte_detected),
        .decoding_failed     (decoding_failed),
        .new_bit_clk         (new_bit_clk),
        .new_bit             (new_bit),
        .out_if              (io.master),
        .busy                (busy),
        .ok_count            (ok_count),
        .err_count           (err_count),
        .drop_count          (drop_count),
        .overflow            (overflow)
    );

    always #5 inclk = ~inclk;

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;
    beat_t exp_q[$];
    logic [7:0] pkt [0:15];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: samples mid-cycle, before the next handshake edge.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    always @(negedge inclk) begin
        #2;
        if (io.out_valid) valid_seen++;
        if (prev_stall && io.out_valid) begin
            check("hold_data", {24'h0, io.out_data}, {24'h0, prev_data});
            check("hold_last", {31'h0, io.out_last}, {31'h0, prev_last});
        end
        prev_stall = io.out_valid && !io.out_ready;
        prev_data  = io.out_data;
        prev_last  = io.out_last;
        if (io.out_valid && io.out_ready) begin
            check("beat_expected", {31'h0, exp_q.size() != 0}, 32'h1);
            if (exp_q.size() != 0) begin
                beat_t e;
                e = exp_q.pop_front();
                check("out_data", {24'h0, io.out_data}, {24'h0, e.d});
                check("out_last", {31'h0, io.out_last}, {31'h0, e.l});
                check("pkt_len",  {29'h0, io.pkt_len},  {29'h0, e.len});
            end
        end
    end

    task automatic send_bit(input logic b);
        new_bit     = b;
        new_bit_clk = 1'b1;
        @(negedge inclk);
        new_bit_clk = 1'b0;
        @(negedge inclk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_pkt(input int n, input logic sbd, input logic fail);
        decoding = 1'b1;
        start_byte_detected = sbd;
        @(negedge inclk);
        for (int i = 0; i < n; i++) send_byte(pkt[i]);
        decoding_failed = fail;
        decoding = 1'b0;
    endtask

    task automatic finish_pkt();
        @(negedge inclk);
        start_byte_detected = 1'b0;
        decoding_failed = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic l, input logic [ADDR_W-1:0] len);
        beat_t e;
        e.d = d; e.l = l; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int max_cycles);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge inclk);
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", {31'h0, done}, 32'h1);
    endtask

    task automatic set_good(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n_pay);
        pkt[0] = b0; pkt[1] = b1; pkt[2] = b2;
        pkt[n_pay]   = 8'hC1;
        pkt[n_pay+1] = 8'hC2;
        pkt[n_pay+2] = 8'hC3;
        pkt[n_pay+3] = 8'hC4;
        pkt[n_pay+4] = 8'h99;
    endtask

    int vs;

    initial begin
        io.out_ready = 1'b1;
        #1;
        check("rst_valid",    {31'h0, io.out_valid}, 32'h0);
        check("rst_data",     {24'h0, io.out_data},  32'h0);
        check("rst_last",     {31'h0, io.out_last},  32'h0);
        check("rst_pkt_len",  {29'h0, io.pkt_len},   32'h0);
        check("rst_busy",     {31'h0, busy},         32'h0);
        check("rst_ok",       {16'h0, ok_count},     32'h0);
        check("rst_err",      {16'h0, err_count},    32'h0);
        check("rst_drop",     {16'h0, drop_count},   32'h0);
        check("rst_overflow", {31'h0, overflow},     32'h0);
        @(negedge inclk); @(negedge inclk);
        reset = 1'b0;
        @(negedge inclk);

        // Good packet, with CHECK/DRAIN latency
        set_good(8'hA5, 8'h3C, 8'hFF, 3);
        push(8'hA5, 1'b0, 3'd3);
        push(8'h3C, 1'b0, 3'd3);
        push(8'hFF, 1'b1, 3'd3);
        send_pkt(8, 1'b1, 1'b0);
        finish_pkt();
        check("lat_n_valid", {31'h0, io.out_valid}, 32'h0);
        check("lat_n_busy",  {31'h0, busy},         32'h1);
        @(negedge inclk);
        check("lat_n1_valid", {31'h0, io.out_valid}, 32'h1);
        wait_idle(50);
        check("good_ok",  {16'h0, ok_count},  32'h1);
        check("good_err", {16'h0, err_count}, 32'h0);

        // Failed packet
        vs = valid_seen;
        send_pkt(8, 1'b1, 1'b1);
        finish_pkt();
        repeat (5) @(negedge inclk);
        check("fail_no_valid", valid_seen, vs);
        check("fail_err",  {16'h0, err_count}, 32'h1);
        check("fail_ok",   {16'h0, ok_count},  32'h1);
        check("fail_busy", {31'h0, busy},      32'h0);

        // False trigger
        decoding = 1'b1;
        repeat (30) @(negedge inclk);
        check("false_busy_recv", {31'h0, busy}, 32'h1);
        decoding = 1'b0;
        repeat (3) @(negedge inclk);
        check("false_idle", {31'h0, busy},       32'h0);
        check("false_ok",   {16'h0, ok_count},   32'h1);
        check("false_err",  {16'h0, err_count},  32'h1);
        check("false_drop", {16'h0, drop_count}, 32'h0);
        check("false_no_valid", valid_seen, vs);

        // Overflow: 12 bytes into an 8-byte buffer
        for (int i = 0; i < 12; i++) pkt[i] = 8'(8'h10 + i);
        send_pkt(12, 1'b1, 1'b0);
        finish_pkt();
        repeat (4) @(negedge inclk);
        check("ovf_flag", {31'h0, overflow},     32'h1);
        check("ovf_err",  {16'h0, err_count},    32'h2);
        check("ovf_ok",   {16'h0, ok_count},     32'h1);
        check("ovf_no_valid", valid_seen, vs);
        set_good(8'h5A, 8'h00, 8'h00, 1);
        push(8'h5A, 1'b1, 3'd1);
        send_pkt(6, 1'b1, 1'b0);
        finish_pkt();
        wait_idle(50);
        check("ovf_next_ok",  {16'h0, ok_count}, 32'h2);
        check("ovf_sticky",   {31'h0, overflow}, 32'h1);

        // Backpressure with a dropped packet arriving during DRAIN
        io.out_ready = 1'b0;
        set_good(8'h11, 8'h22, 8'h00, 2);
        push(8'h11, 1'b0, 3'd2);
        push(8'h22, 1'b1, 3'd2);
        send_pkt(7, 1'b1, 1'b0);
        finish_pkt();
        @(negedge inclk);
        check("bp_valid",   {31'h0, io.out_valid}, 32'h1);
        check("bp_data",    {24'h0, io.out_data},  32'h11);
        check("bp_last",    {31'h0, io.out_last},  32'h0);
        check("bp_pkt_len", {29'h0, io.pkt_len},   32'h2);
        pkt[0] = 8'hE7;
        send_pkt(1, 1'b1, 1'b0);
        finish_pkt();
        repeat (3) @(negedge inclk);
        check("bp_drop",      {16'h0, drop_count}, 32'h1);
        check("bp_data_held", {24'h0, io.out_data}, 32'h11);
        check("bp_busy",      {31'h0, busy},        32'h1);
        repeat (15) @(negedge inclk);
        io.out_ready = 1'b1;
        wait_idle(50);
        check("bp_ok",   {16'h0, ok_count},   32'h3);
        check("bp_drop_final", {16'h0, drop_count}, 32'h1);

        // Asynchronous reset in the middle of RECV
        decoding = 1'b1;
        start_byte_detected = 1'b1;
        @(negedge inclk);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        check("pre_rst_busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        #1;
        check("arst_busy",  {31'h0, busy},        32'h0);
        check("arst_valid", {31'h0, io.out_valid}, 32'h0);
        check("arst_ok",    {16'h0, ok_count},    32'h0);
        check("arst_err",   {16'h0, err_count},   32'h0);
        check("arst_drop",  {16'h0, drop_count},  32'h0);
        check("arst_ovf",   {31'h0, overflow},    32'h0);
        check("arst_len",   {29'h0, io.pkt_len},  32'h0);
        @(negedge inclk);
        decoding = 1'b0;
        start_byte_detected = 1'b0;
        repeat (2) @(negedge inclk);
        reset = 1'b0;
        @(negedge inclk);
        set_good(8'h77, 8'h00, 8'h00, 1);
        push(8'h77, 1'b1, 3'd1);
        send_pkt(6, 1'b1, 1'b0);
        finish_pkt();
        wait_idle(50);
        check("post_rst_ok",   {16'h0, ok_count},   32'h1);
        check("post_rst_err",  {16'h0, err_count},  32'h0);
        check("post_rst_drop", {16'h0, drop_count}, 32'h0);

        repeat (3) @(negedge inclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
